memory_controller: RTL and testbench
====================================

# memory_controller

Byte-serial RAM controller and arbiter between the instruction fetch unit and the LoadStoreBuffer. Accepts one access at a time and sequences it over the 8-bit RAM port, which has one cycle of read latency. Returns fetched instructions to the fetch unit and load/store completions, tagged with the LSB slot, to the LSB. Drives the `mem_busy` and `inst_need_work` signals the LSB uses to gate its issue.

## Interface
Parameters:
- `LSB_CAP_BIT`, default `` `LSB_CAP_BIT ``: width of the LSB slot tag.
- `IO_MASK_HI`, default 17: IO region is `addr[17:16]==2'b11`, checked on bits IO_MASK_HI..IO_MASK_HI-1.

Ports:
- `clk_in` in 1: the single clock.
- `rst_n_in` in 1: synchronous, active-low reset.
- `rdy_in` in 1: when low, freeze all state.
- `clear` in 1: ROB flush.
- `io_buffer_full` in 1: UART buffer full.
- `mem_din` in 8: RAM read data.
- `mem_dout` out 8: RAM write data.
- `mem_a` out 32: RAM address.
- `mem_wr` out 1: RAM write enable (1 = write).
- `if_req` in 1: fetch request; level, held until `if_ready`.
- `if_addr` in 32: fetch PC.
- `if_ready` out 1: one-cycle pulse, fetched word valid.
- `if_inst` out 32: fetched word.
- `inst_need_work` out 1: equals `if_req`; tells the LSB not to issue.
- `lsb_req` in 1: one-cycle LSB request pulse.
- `lsb_pos` in LSB_CAP_BIT: LSB slot tag.
- `lsb_ls` in 1: 0 = load, 1 = store.
- `lsb_len` in 2: 00 byte, 01 half, 10 word.
- `lsb_addr` in 32: access address.
- `lsb_val` in 32: store data.
- `mem_busy` out 1: high whenever state is not IDLE.
- `mem_finished` out 1: one-cycle pulse, LSB access done.
- `mem_val` out 32: load data, zero-extended raw bytes.
- `mem_pos` out LSB_CAP_BIT: echoed `lsb_pos`.

## Operation
- States: IDLE, FETCH, LOAD, STORE. Latched per access: base address, byte count n = 1<<len (n=4 for fetch), byte counter `cnt` (3 bits), 32-bit assembly register, tag.
- In IDLE, `lsb_req` has priority over `if_req`.
  - `lsb_req` is always accepted in IDLE. The LSB only issues when `mem_busy` and `inst_need_work` were low, so a same-cycle `if_req` waits.
  - `lsb_ls` selects STORE or LOAD.
  - `if_req` with no `lsb_req` goes to FETCH.
- FETCH/LOAD: drive `mem_a = base+cnt`, `mem_wr=0` for cnt=0..n-1. Capture `mem_din` of the previous cycle into byte cnt-1 (little-endian). After byte n-1 is captured, pulse `if_ready` or `mem_finished` and return to IDLE.
- STORE: drive `mem_a = base+cnt`, `mem_dout = val[8cnt+7:8cnt]`, `mem_wr=1`. Increment `cnt`. After byte n-1, pulse `mem_finished` (`mem_val=0`) and return to IDLE.
- IO store: while `io_buffer_full` is high, the pending byte is not driven (`mem_wr=0`) and `cnt` holds.
- Addresses wrap modulo 2^32.
- `clear`:
  - FETCH or LOAD: aborted immediately, no completion pulse, go to IDLE.
  - STORE: runs to completion, since stores issue only at the ROB head. Its `mem_finished` pulse is still produced.
  - A `lsb_req` or `if_req` in the clear cycle is ignored.
- `rdy_in` low: state, counters and outputs hold, except `mem_wr` is forced 0. Pulses are not repeated.
- Completion pulses and `mem_busy` are registered.

## Timing
- Reset (rst_n_in low at a clock edge): state IDLE; all outputs 0 (`mem_a`, `mem_dout`, `mem_wr`, `if_ready`, `if_inst`, `mem_busy`, `mem_finished`, `mem_val`, `mem_pos`). Reset mid-access abandons it with no pulse.
- Request accepted at edge t:
  - First address on `mem_a` in cycle t+1.
  - `mem_busy` high from t+1.
  - Read of n bytes: pulse in cycle t+n+2, `mem_busy` low in that same cycle. Word = 6 cycles, byte = 3 cycles.
  - Write of n bytes: `mem_wr` high in cycles t+1..t+n, pulse in t+n+1. Each IO stall cycle adds one.
- Back-to-back: a new request can be accepted in the completion-pulse cycle.
- `if_inst`, `mem_val` and `mem_pos` are valid only during their pulse and hold afterwards.

## Structure
- `const.v` holds the state encodings (`MC_IDLE`, `MC_FETCH`, `MC_LOAD`, `MC_STORE`), the IO-region test bits, and the `lsb_len` encoding shared with the LSB.
- Single module; no sub-module is needed. Byte assembly and the counter are inline.

## Test plan
- Fetch: `if_req=1`, `if_addr=0x100`, RAM[0x100..0x103] = 13 05 00 00 -> `mem_a` 0x100..0x103 in t+1..t+4; `if_ready` at t+6 with `if_inst=0x00000513`.
- Same-cycle arbitration: `lsb_req` (LW @0x200, RAM = EF BE AD DE, pos=5) with `if_req` -> LOAD first; `mem_finished`, `mem_val=0xDEADBEEF`, `mem_pos=5`; FETCH starts the next cycle.
- SH of `0x1234ABCD` @0x301 -> writes CD @0x301 then AB @0x302; `mem_finished` at t+3; RAM[0x303] unchanged.
- IO SB @0x30000, `io_buffer_full` high for 3 cycles -> `mem_wr` stays 0 for 3 cycles, then 1 write; pulse delayed by 3.
- `clear` in cycle t+2 of an LW -> no `mem_finished`, IDLE at t+3. `clear` during an SW -> all 4 bytes written and the pulse is produced.
- `rdy_in` low for 2 cycles mid-fetch -> `mem_wr=0`, latency +2, data correct. `rst_n_in` low mid-STORE -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/memory_controller_pkg.sv
// Shared encodings for the byte-serial RAM controller: FSM states, access
// length codes used by the LoadStoreBuffer, and the IO-region tag.
package memory_controller_pkg;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_FETCH = 2'd1,
    MC_LOAD  = 2'd2,
    MC_STORE = 2'd3
  } mc_state_e;

  localparam int         LSB_CAP_BIT_DEF = 3;
  localparam logic [1:0] LEN_BYTE        = 2'b00;
  localparam logic [1:0] LEN_HALF        = 2'b01;
  localparam logic [1:0] LEN_WORD        = 2'b10;
  localparam logic [1:0] IO_REGION       = 2'b11;
  localparam logic [2:0] WORD_BYTES      = 3'd4;

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      LEN_BYTE: len_to_n = 3'd1;
      LEN_HALF: len_to_n = 3'd2;
      default:  len_to_n = WORD_BYTES;
    endcase
  endfunction

endpackage

// File: rtl/memory_controller.sv
// Byte-serial RAM controller arbitrating between instruction fetch and the
// LoadStoreBuffer; sequences one access at a time over the 8-bit RAM port.
//
// state    | meaning
// MC_IDLE  | no access in flight, arbitrate lsb_req over if_req
// MC_FETCH | reading a 4-byte instruction word
// MC_LOAD  | reading 1/2/4 bytes for the LSB
// MC_STORE | writing 1/2/4 bytes, stalls on io_buffer_full in the IO region
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int LSB_CAP_BIT = LSB_CAP_BIT_DEF,
  parameter int IO_MASK_HI  = 17
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic                   io_buffer_full,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [31:0]            mem_a,
  output logic                   mem_wr,
  input  logic                   if_req,
  input  logic [31:0]            if_addr,
  output logic                   if_ready,
  output logic [31:0]            if_inst,
  output logic                   inst_need_work,
  input  logic                   lsb_req,
  input  logic [LSB_CAP_BIT-1:0] lsb_pos,
  input  logic                   lsb_ls,
  input  logic [1:0]             lsb_len,
  input  logic [31:0]            lsb_addr,
  input  logic [31:0]            lsb_val,
  output logic                   mem_busy,
  output logic                   mem_finished,
  output logic [31:0]            mem_val,
  output logic [LSB_CAP_BIT-1:0] mem_pos
);

  mc_state_e              state, state_next;
  logic [31:0]            base;
  logic [2:0]             cnt;
  logic [2:0]             n_bytes;
  logic [31:0]            val_q;
  logic [31:0]            asm_q;
  logic [31:0]            asm_next;
  logic [LSB_CAP_BIT-1:0] tag;
  logic                   rdy_q;
  logic [7:0]             din_hold;
  logic [7:0]             din_eff;
  logic [7:0]             st_byte;
  logic [1:0]             rd_idx;
  logic                   is_io;
  logic                   accept_lsb, accept_if;
  logic                   rd_step, rd_done, st_step, st_done;

  assign mem_a          = base + {29'b0, cnt};
  assign is_io          = (mem_a[IO_MASK_HI -: 2] == IO_REGION);
  assign mem_busy       = (state != MC_IDLE);
  assign inst_need_work = if_req;
  assign mem_dout       = (state == MC_STORE) ? st_byte : 8'h00;

  // The RAM keeps answering while rdy_in is low, so the byte that arrived
  // just as the stall began is parked here and consumed on resume.
  assign din_eff  = rdy_q ? mem_din : din_hold;
  assign rd_idx   = cnt[1:0] - 2'd1;
  assign asm_next = asm_q | ({24'b0, din_eff} << {rd_idx, 3'b000});

  always_comb begin
    case (cnt[1:0])
      2'd0:    st_byte = val_q[7:0];
      2'd1:    st_byte = val_q[15:8];
      2'd2:    st_byte = val_q[23:16];
      default: st_byte = val_q[31:24];
    endcase
  end

  always_comb begin
    state_next = state;
    accept_lsb = 1'b0;
    accept_if  = 1'b0;
    rd_step    = 1'b0;
    rd_done    = 1'b0;
    st_step    = 1'b0;
    st_done    = 1'b0;
    mem_wr     = 1'b0;
    if (rdy_in) begin
      case (state)
        MC_IDLE: begin
          if (!clear) begin
            if (lsb_req) begin
              accept_lsb = 1'b1;
              state_next = lsb_ls ? MC_STORE : MC_LOAD;
            end else if (if_req) begin
              accept_if  = 1'b1;
              state_next = MC_FETCH;
            end
          end
        end
        MC_FETCH, MC_LOAD: begin
          if (clear) begin
            state_next = MC_IDLE;
          end else if (cnt == n_bytes) begin
            rd_done    = 1'b1;
            state_next = MC_IDLE;
          end else begin
            rd_step = 1'b1;
          end
        end
        MC_STORE: begin
          // Stores ignore clear: they only issue once committed.
          if (!(is_io && io_buffer_full)) begin
            mem_wr = 1'b1;
            if (cnt == n_bytes - 3'd1) begin
              st_done    = 1'b1;
              state_next = MC_IDLE;
            end else begin
              st_step = 1'b1;
            end
          end
        end
        default: state_next = MC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state <= MC_IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      base         <= 32'h0;
      cnt          <= 3'd0;
      n_bytes      <= 3'd0;
      val_q        <= 32'h0;
      asm_q        <= 32'h0;
      tag          <= '0;
      rdy_q        <= 1'b1;
      din_hold     <= 8'h00;
      if_ready     <= 1'b0;
      if_inst      <= 32'h0;
      mem_finished <= 1'b0;
      mem_val      <= 32'h0;
      mem_pos      <= '0;
    end else begin
      rdy_q        <= rdy_in;
      if_ready     <= 1'b0;
      mem_finished <= 1'b0;
      if (rdy_q) din_hold <= mem_din;
      if (accept_lsb) begin
        base    <= lsb_addr;
        cnt     <= 3'd0;
        n_bytes <= len_to_n(lsb_len);
        val_q   <= lsb_val;
        tag     <= lsb_pos;
        asm_q   <= 32'h0;
      end
      if (accept_if) begin
        base    <= if_addr;
        cnt     <= 3'd0;
        n_bytes <= WORD_BYTES;
        asm_q   <= 32'h0;
      end
      if (rd_step) begin
        cnt <= cnt + 3'd1;
        if (cnt != 3'd0) asm_q <= asm_next;
      end
      if (rd_done) begin
        if (state == MC_FETCH) begin
          if_ready <= 1'b1;
          if_inst  <= asm_next;
        end else begin
          mem_finished <= 1'b1;
          mem_val      <= asm_next;
          mem_pos      <= tag;
        end
      end
      if (st_step) cnt <= cnt + 3'd1;
      if (st_done) begin
        mem_finished <= 1'b1;
        mem_val      <= 32'h0;
        mem_pos      <= tag;
      end
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller with a one-cycle-latency byte RAM model.
module tb_memory_controller;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, clear, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_inst;
  logic        inst_need_work;
  logic        lsb_req;
  logic [2:0]  lsb_pos;
  logic        lsb_ls;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_addr, lsb_val;
  logic        mem_busy, mem_finished;
  logic [31:0] mem_val;
  logic [2:0]  mem_pos;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] ram [0:262143];

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
  end

  memory_controller #(.LSB_CAP_BIT(3), .IO_MASK_HI(17)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear(clear),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .if_req(if_req), .if_addr(if_addr),
    .if_ready(if_ready), .if_inst(if_inst), .inst_need_work(inst_need_work),
    .lsb_req(lsb_req), .lsb_pos(lsb_pos), .lsb_ls(lsb_ls), .lsb_len(lsb_len),
    .lsb_addr(lsb_addr), .lsb_val(lsb_val), .mem_busy(mem_busy),
    .mem_finished(mem_finished), .mem_val(mem_val), .mem_pos(mem_pos)
  );

  task automatic nxt;
    @(posedge clk_in);
    #1;
  endtask

  task automatic mid;
    @(negedge clk_in);
  endtask

  task automatic lsb_issue(input logic ls, input logic [1:0] len, input logic [31:0] addr,
                           input logic [31:0] val, input logic [2:0] pos);
    lsb_req = 1'b1; lsb_ls = ls; lsb_len = len; lsb_addr = addr; lsb_val = val; lsb_pos = pos;
  endtask

  task automatic test_reset;
    rst_n_in = 1'b0;
    nxt; nxt; mid;
    vectors++;
    if ({mem_a, mem_dout, mem_wr, if_ready, if_inst, mem_busy, mem_finished, mem_val, mem_pos} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: mem_a=%h dout=%h wr=%b rdy=%b inst=%h busy=%b fin=%b val=%h pos=%h, expected all 0",
               mem_a, mem_dout, mem_wr, if_ready, if_inst, mem_busy, mem_finished, mem_val, mem_pos);
    end
    rst_n_in = 1'b1;
    nxt;
  endtask

  task automatic test_fetch;
    if_req = 1'b1; if_addr = 32'h100;
    nxt;
    for (int k = 0; k < 4; k++) begin
      mid;
      vectors++;
      if (mem_a !== 32'h100 + k || mem_wr !== 1'b0 || mem_busy !== 1'b1 || inst_need_work !== 1'b1) begin
        miscompares++;
        $display("FAIL fetch_addr[%0d]: mem_a=%h wr=%b busy=%b need=%b, expected %h 0 1 1",
                 k, mem_a, mem_wr, mem_busy, inst_need_work, 32'h100 + k);
      end
      nxt;
    end
    mid;
    vectors++;
    if (if_ready !== 1'b0) begin
      miscompares++; $display("FAIL fetch_early: if_ready=%b expected 0", if_ready);
    end
    nxt;
    if_req = 1'b0;
    mid;
    vectors++;
    if (if_ready !== 1'b1 || if_inst !== 32'h00000513 || mem_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_done: if_ready=%b inst=%h busy=%b expected 1 00000513 0", if_ready, if_inst, mem_busy);
    end
    nxt;
  endtask

  task automatic test_arbitration;
    lsb_issue(1'b0, 2'b10, 32'h200, 32'h0, 3'd5);
    if_req = 1'b1; if_addr = 32'h100;
    nxt;
    lsb_req = 1'b0;
    mid;
    vectors++;
    if (mem_a !== 32'h200) begin
      miscompares++; $display("FAIL arb_first: mem_a=%h expected 00000200", mem_a);
    end
    repeat (5) nxt;
    mid;
    vectors++;
    if (mem_finished !== 1'b1 || mem_val !== 32'hDEADBEEF || mem_pos !== 3'd5 || mem_busy !== 1'b0 || if_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL arb_load: fin=%b val=%h pos=%0d busy=%b if_ready=%b expected 1 deadbeef 5 0 0",
               mem_finished, mem_val, mem_pos, mem_busy, if_ready);
    end
    nxt;
    mid;
    vectors++;
    if (mem_busy !== 1'b1 || mem_a !== 32'h100) begin
      miscompares++; $display("FAIL arb_fetch_start: busy=%b mem_a=%h expected 1 00000100", mem_busy, mem_a);
    end
    repeat (5) nxt;
    if_req = 1'b0;
    mid;
    vectors++;
    if (if_ready !== 1'b1 || if_inst !== 32'h00000513) begin
      miscompares++; $display("FAIL arb_fetch_done: if_ready=%b inst=%h expected 1 00000513", if_ready, if_inst);
    end
    nxt;
  endtask

  task automatic test_back_to_back;
    lsb_issue(1'b0, 2'b00, 32'h203, 32'h0, 3'd4);
    nxt;
    lsb_req = 1'b0;
    nxt; nxt;
    lsb_issue(1'b0, 2'b01, 32'h202, 32'h0, 3'd6);
    mid;
    vectors++;
    if (mem_finished !== 1'b1 || mem_val !== 32'h000000DE || mem_pos !== 3'd4) begin
      miscompares++;
      $display("FAIL lb_done: fin=%b val=%h pos=%0d expected 1 000000de 4", mem_finished, mem_val, mem_pos);
    end
    nxt;
    lsb_req = 1'b0;
    mid;
    vectors++;
    if (mem_a !== 32'h202 || mem_busy !== 1'b1) begin
      miscompares++; $display("FAIL b2b_start: mem_a=%h busy=%b expected 00000202 1", mem_a, mem_busy);
    end
    repeat (3) nxt;
    mid;
    vectors++;
    if (mem_finished !== 1'b1 || mem_val !== 32'h0000DEAD || mem_pos !== 3'd6) begin
      miscompares++;
      $display("FAIL lh_done: fin=%b val=%h pos=%0d expected 1 0000dead 6", mem_finished, mem_val, mem_pos);
    end
    nxt;
  endtask

  task automatic test_store_half;
    lsb_issue(1'b1, 2'b01, 32'h301, 32'h1234ABCD, 3'd2);
    nxt;
    lsb_req = 1'b0;
    mid;
    vectors++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h301 || mem_dout !== 8'hCD) begin
      miscompares++; $display("FAIL sh_byte0: wr=%b a=%h dout=%h expected 1 00000301 cd", mem_wr, mem_a, mem_dout);
    end
    nxt;
    mid;
    vectors++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h302 || mem_dout !== 8'hAB) begin
      miscompares++; $display("FAIL sh_byte1: wr=%b a=%h dout=%h expected 1 00000302 ab", mem_wr, mem_a, mem_dout);
    end
    nxt;
    mid;
    vectors++;
    if (mem_finished !== 1'b1 || mem_val !== 32'h0 || mem_pos !== 3'd2 || mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL sh_done: fin=%b val=%h pos=%0d wr=%b expected 1 0 2 0", mem_finished, mem_val, mem_pos, mem_wr);
    end
    nxt;
    vectors++;
    if ({ram[18'h303], ram[18'h302], ram[18'h301]} !== 24'h77ABCD) begin
      miscompares++;
      $display("FAIL sh_ram: ram[303..301]=%h%h%h expected 77abcd", ram[18'h303], ram[18'h302], ram[18'h301]);
    end
  endtask

  task automatic test_io_store;
    lsb_issue(1'b1, 2'b00, 32'h30000, 32'h0000005A, 3'd1);
    nxt;
    lsb_req = 1'b0;
    io_buffer_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid;
      vectors++;
      if (mem_wr !== 1'b0 || mem_a !== 32'h30000 || mem_finished !== 1'b0) begin
        miscompares++;
        $display("FAIL io_stall[%0d]: wr=%b a=%h fin=%b expected 0 00030000 0", k, mem_wr, mem_a, mem_finished);
      end
      nxt;
    end
    io_buffer_full = 1'b0;
    mid;
    vectors++;
    if (mem_wr !== 1'b1 || mem_dout !== 8'h5A) begin
      miscompares++; $display("FAIL io_write: wr=%b dout=%h expected 1 5a", mem_wr, mem_dout);
    end
    nxt;
    mid;
    vectors++;
    if (mem_finished !== 1'b1 || mem_pos !== 3'd1) begin
      miscompares++; $display("FAIL io_done: fin=%b pos=%0d expected 1 1", mem_finished, mem_pos);
    end
    nxt;
    vectors++;
    if (ram[18'h30000] !== 8'h5A) begin
      miscompares++; $display("FAIL io_ram: ram[30000]=%h expected 5a", ram[18'h30000]);
    end
  endtask

  task automatic test_clear;
    logic seen;
    lsb_issue(1'b0, 2'b10, 32'h200, 32'h0, 3'd7);
    nxt;
    lsb_req = 1'b0;
    nxt;
    clear = 1'b1;
    mid;
    vectors++;
    if (mem_busy !== 1'b1) begin
      miscompares++; $display("FAIL clr_ld_busy: busy=%b expected 1", mem_busy);
    end
    nxt;
    clear = 1'b0;
    mid;
    vectors++;
    if (mem_busy !== 1'b0) begin
      miscompares++; $display("FAIL clr_ld_idle: busy=%b expected 0", mem_busy);
    end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      nxt; mid;
      if (mem_finished !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL clr_ld_pulse: mem_finished seen=%b expected 0", seen);
    end
    nxt;
    clear = 1'b1;
    lsb_issue(1'b0, 2'b00, 32'h200, 32'h0, 3'd1);
    nxt;
    clear = 1'b0; lsb_req = 1'b0;
    mid;
    vectors++;
    if (mem_busy !== 1'b0) begin
      miscompares++; $display("FAIL clr_req_ignored: busy=%b expected 0", mem_busy);
    end
    nxt;
    lsb_issue(1'b1, 2'b10, 32'h400, 32'hCAFEF00D, 3'd3);
    nxt;
    lsb_req = 1'b0;
    clear = 1'b1;
    nxt;
    clear = 1'b0;
    mid;
    vectors++;
    if (mem_busy !== 1'b1 || mem_a !== 32'h401) begin
      miscompares++; $display("FAIL clr_st_continue: busy=%b a=%h expected 1 00000401", mem_busy, mem_a);
    end
    repeat (3) nxt;
    mid;
    vectors++;
    if (mem_finished !== 1'b1 || mem_pos !== 3'd3) begin
      miscompares++; $display("FAIL clr_st_done: fin=%b pos=%0d expected 1 3", mem_finished, mem_pos);
    end
    nxt;
    vectors++;
    if ({ram[18'h403], ram[18'h402], ram[18'h401], ram[18'h400]} !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL clr_st_ram: ram[403..400]=%h%h%h%h expected cafef00d",
               ram[18'h403], ram[18'h402], ram[18'h401], ram[18'h400]);
    end
  endtask

  task automatic test_rdy_fetch;
    if_req = 1'b1; if_addr = 32'h500;
    nxt;
    mid;
    vectors++;
    if (mem_a !== 32'h500) begin
      miscompares++; $display("FAIL rdy_first: a=%h expected 00000500", mem_a);
    end
    nxt;
    rdy_in = 1'b0;
    mid;
    vectors++;
    if (mem_wr !== 1'b0 || mem_a !== 32'h501) begin
      miscompares++; $display("FAIL rdy_low0: wr=%b a=%h expected 0 00000501", mem_wr, mem_a);
    end
    nxt;
    mid;
    vectors++;
    if (mem_a !== 32'h501 || mem_busy !== 1'b1) begin
      miscompares++; $display("FAIL rdy_low1: a=%h busy=%b expected 00000501 1", mem_a, mem_busy);
    end
    nxt;
    rdy_in = 1'b1;
    repeat (3) nxt;
    mid;
    vectors++;
    if (if_ready !== 1'b0) begin
      miscompares++; $display("FAIL rdy_early: if_ready=%b expected 0", if_ready);
    end
    nxt;
    if_req = 1'b0;
    mid;
    vectors++;
    if (if_ready !== 1'b1 || if_inst !== 32'h12345678) begin
      miscompares++; $display("FAIL rdy_done: if_ready=%b inst=%h expected 1 12345678", if_ready, if_inst);
    end
    nxt;
  endtask

  task automatic test_reset_mid_store;
    lsb_issue(1'b1, 2'b10, 32'h600, 32'h11223344, 3'd1);
    nxt;
    lsb_req = 1'b0;
    mid;
    vectors++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h600 || mem_dout !== 8'h44) begin
      miscompares++; $display("FAIL rst_st_b0: wr=%b a=%h dout=%h expected 1 00000600 44", mem_wr, mem_a, mem_dout);
    end
    nxt;
    rdy_in = 1'b0;
    mid;
    vectors++;
    if (mem_wr !== 1'b0 || mem_a !== 32'h601) begin
      miscompares++; $display("FAIL rst_st_rdy: wr=%b a=%h expected 0 00000601", mem_wr, mem_a);
    end
    nxt;
    rdy_in = 1'b1;
    mid;
    vectors++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h601 || mem_dout !== 8'h33) begin
      miscompares++; $display("FAIL rst_st_b1: wr=%b a=%h dout=%h expected 1 00000601 33", mem_wr, mem_a, mem_dout);
    end
    nxt;
    rst_n_in = 1'b0;
    nxt;
    rst_n_in = 1'b1;
    mid;
    vectors++;
    if ({mem_a, mem_dout, mem_wr, if_ready, if_inst, mem_busy, mem_finished, mem_val, mem_pos} !== '0) begin
      miscompares++;
      $display("FAIL rst_st_outputs: mem_a=%h dout=%h wr=%b rdy=%b inst=%h busy=%b fin=%b val=%h pos=%h, expected all 0",
               mem_a, mem_dout, mem_wr, if_ready, if_inst, mem_busy, mem_finished, mem_val, mem_pos);
    end
    nxt;
    vectors++;
    if ({ram[18'h603], ram[18'h602], ram[18'h601]} !== 24'h002233) begin
      miscompares++;
      $display("FAIL rst_st_ram: ram[603..601]=%h%h%h expected 002233", ram[18'h603], ram[18'h602], ram[18'h601]);
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    {ram[18'h103], ram[18'h102], ram[18'h101], ram[18'h100]} = 32'h00000513;
    {ram[18'h203], ram[18'h202], ram[18'h201], ram[18'h200]} = 32'hDEADBEEF;
    {ram[18'h503], ram[18'h502], ram[18'h501], ram[18'h500]} = 32'h12345678;
    ram[18'h303] = 8'h77;
    rst_n_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    lsb_req = 1'b0; lsb_pos = 3'd0; lsb_ls = 1'b0; lsb_len = 2'b00;
    lsb_addr = 32'h0; lsb_val = 32'h0;
    test_reset;
    test_fetch;
    test_arbitration;
    test_back_to_back;
    test_store_half;
    test_io_store;
    test_clear;
    test_rdy_fetch;
    test_reset_mid_store;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
